pwm_motor_ctrl: RTL and testbench
=================================

Name: pwm_motor_ctrl

Overview:
Parametrised PWM speed controller for a DC motor driver with an nSLEEP-style enable pin. Two pushbutton-level inputs (inc/dec) adjust a duty target in STEP increments while held, with auto-repeat every HOLD_CYC cycles, saturating at DUTY_MIN/DUTY_MAX. New duty values take effect only at a PWM period boundary, so the output is glitch-free. The block sits between the button synchroniser/debouncer and the motor driver pins.

Parameters:
PERIOD, 2000, PWM period in clk cycles (>=2).
DUTY_INIT, 1000, duty after reset, in high-cycles per period.
DUTY_MIN, 50, lower duty limit; DUTY_MIN <= DUTY_INIT.
DUTY_MAX, 1950, upper duty limit; DUTY_INIT <= DUTY_MAX <= PERIOD.
STEP, 1, duty change per repeat step (>=1).
HOLD_CYC, 100, cycles of continuous press per step (>=1).
W, $clog2(PERIOD+1), width of the counter and duty registers (derived; not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  motor enable; low = coast/sleep
inc  in  1  increase request, already synchronised, level
dec  in  1  decrease request, already synchronised, level
pwm_out  out  1  registered PWM drive
nsleep  out  1  registered driver enable (follows en)
duty  out  W  currently active duty (applied value)
at_max  out  1  duty target == DUTY_MAX
at_min  out  1  duty target == DUTY_MIN

Behaviour:
- Reset (async, immediate): cnt=0, hold=0, target=DUTY_INIT, duty=DUTY_INIT, pwm_out=0, nsleep=0, state=IDLE.
- Period counter cnt: 0..PERIOD-1, increments each cycle while en=1 and wraps to 0 after PERIOD-1. While en=0, cnt is held at 0.
- pwm_out <= en & (cnt < duty). One-cycle latency from cnt. Exactly duty high-cycles per period. duty=0 gives constant low; duty=PERIOD gives constant high.
- nsleep <= en (one-cycle latency). pwm_out and nsleep deassert together on the cycle after en falls.
- Duty shadowing: duty <= target only on the cycle where cnt==PERIOD-1 (period wrap), or while en=0. target changes mid-period never alter the current period.
- Press qualification: press = en & (inc ^ dec). Both high or both low means no press.
- Hold counter hold: if !press, or the direction changes from the previous cycle, hold <= 0. Otherwise hold counts up.
- When hold == HOLD_CYC-1, a one-cycle step pulse fires and hold <= 0. The first step therefore occurs HOLD_CYC cycles after the press begins, and repeats every HOLD_CYC cycles while held.
- Step arithmetic: compute in W+1 bits.
  - inc step: target <= min(target+STEP, DUTY_MAX).
  - dec step: target <= max(target-STEP, DUTY_MIN). Guard against underflow when target < STEP.
- State machine, registered, 3 bits:
  - IDLE: no press and DUTY_MIN < target < DUTY_MAX.
  - INC: inc press and target < DUTY_MAX.
  - DEC: dec press and target > DUTY_MIN.
  - MAX: target == DUTY_MAX and no dec press. Inc presses are ignored: hold stays 0 and no step occurs.
  - MIN: target == DUTY_MIN and no inc press. Dec presses are ignored likewise.
  - Next state is evaluated each cycle from the post-step target. INC->MAX on the step that reaches DUTY_MAX. MAX->DEC on a dec press. MIN->INC on an inc press. Any press->IDLE on release, unless at a limit.
  - With DUTY_MIN == DUTY_MAX, MAX takes priority and all steps are suppressed.
- at_max / at_min are combinational compares of target. Both are high when DUTY_MIN == DUTY_MAX.
- en=0 mid-press: hold clears and no step occurs. target is retained. On re-enable, cnt restarts at 0 with duty=target.
- Reset mid-period: pwm_out drops asynchronously and duty returns to DUTY_INIT.

Decomposition:
- Shared package pwm_motor_pkg holds the state encodings (IDLE=0, INC=1, DEC=2, MAX=3, MIN=4) and the clamp helper functions.
- One sub-module is natural: pwm_step_repeat. It takes (clk, rst, press, dir) and produces step pulse + dir, parametrised by HOLD_CYC.
- The counter, shadow register and FSM stay in the top level.

Test Plan:
- Reset release with en=1, no press, defaults → pwm_out high for exactly 1000 of every 2000 cycles. duty=1000, nsleep=1 one cycle after en.
- Hold inc for 250 cycles → two steps, at cycles 100 and 200. target=1002. duty updates to 1002 only at the next cnt==1999 wrap. The third step never occurs after release.
- Override DUTY_INIT=1948, STEP=5; hold inc → target clamps at 1950, at_max=1, state=MAX. Further inc holding leaves target=1950. A dec press then moves to DEC, and after 100 cycles target=1945.
- Hold inc and dec together for 300 cycles → no step, state IDLE. Toggling direction every 60 cycles → no step ever fires.
- Deassert en mid-period while inc is held → next cycle pwm_out=0, nsleep=0, cnt=0, target unchanged. Re-enable → fresh period starting at cnt=0.
- Assert rst asynchronously mid-high-phase → pwm_out=0 immediately, duty=1000, state=IDLE. Normal PWM resumes after release.

Source files
------------

// File: rtl/pwm_motor_pkg.sv
// Shared definitions for the PWM motor controller: FSM state encoding and
// saturating duty-step helpers.
package pwm_motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INC  = 3'd1,
    ST_DEC  = 3'd2,
    ST_MAX  = 3'd3,
    ST_MIN  = 3'd4
  } state_e;

  // Saturating increment; 32-bit arithmetic leaves headroom above any duty width.
  function automatic int unsigned clamp_up(input int unsigned val,
                                           input int unsigned step,
                                           input int unsigned hi);
    int unsigned sum;
    sum = val + step;
    return (sum > hi) ? hi : sum;
  endfunction

  // Saturating decrement; comparing before subtracting avoids underflow when val < step.
  function automatic int unsigned clamp_dn(input int unsigned val,
                                           input int unsigned step,
                                           input int unsigned lo);
    return (val < lo + step) ? lo : val - step;
  endfunction

endpackage

// File: rtl/pwm_step_repeat.sv
// Press-and-hold auto-repeat: emits a one-cycle step pulse after HOLD_CYC
// cycles of continuous press in one direction, repeating every HOLD_CYC cycles.
//   clk, rst  : clock, async active-high reset
//   press     : qualified press request (already gated by limits)
//   dir       : 1 = increase, 0 = decrease
//   step      : one-cycle step pulse
//   step_dir  : direction that accompanies step
module pwm_step_repeat #(
  parameter int unsigned HOLD_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic dir,
  output logic step,
  output logic step_dir
);

  localparam int unsigned   HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          prev_press_q, prev_press_d;
  logic          prev_dir_q, prev_dir_d;
  logic          dir_chg;

  always_comb begin
    // A reversal only counts when the previous cycle was itself a press.
    dir_chg      = prev_press_q & (dir != prev_dir_q);
    step         = 1'b0;
    hold_d       = hold_q;
    prev_press_d = press;
    prev_dir_d   = dir;
    if (!press || dir_chg) begin
      hold_d = '0;
    end else if (hold_q == HOLD_LAST) begin
      hold_d = '0;
      step   = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign step_dir = dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      prev_press_q <= 1'b0;
      prev_dir_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      prev_press_q <= prev_press_d;
      prev_dir_q   <= prev_dir_d;
    end
  end

endmodule

// File: rtl/pwm_motor_ctrl.sv
// PWM speed controller for a DC motor driver with nSLEEP-style enable.
// inc/dec held levels step the duty target with auto-repeat; the applied duty
// is shadowed and only updated at a period wrap (or while disabled).
//   clk, rst : clock, async active-high reset
//   en       : motor enable (low = coast/sleep)
//   inc, dec : synchronised press levels
//   pwm_out  : registered PWM drive
//   nsleep   : registered driver enable
//   duty     : applied duty (high cycles per period)
//   at_max   : target at DUTY_MAX
//   at_min   : target at DUTY_MIN
module pwm_motor_ctrl
  import pwm_motor_pkg::*;
#(
  parameter int unsigned PERIOD    = 2000,
  parameter int unsigned DUTY_INIT = 1000,
  parameter int unsigned DUTY_MIN  = 50,
  parameter int unsigned DUTY_MAX  = 1950,
  parameter int unsigned STEP      = 1,
  parameter int unsigned HOLD_CYC  = 100,
  parameter int unsigned W         = $clog2(PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic         pwm_out,
  output logic         nsleep,
  output logic [W-1:0] duty,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] CNT_LAST = W'(PERIOD - 1);
  localparam logic [W-1:0] D_INIT   = W'(DUTY_INIT);
  localparam logic [W-1:0] D_MIN    = W'(DUTY_MIN);
  localparam logic [W-1:0] D_MAX    = W'(DUTY_MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] target_q, target_d;
  logic         pwm_q, pwm_d;
  logic         nsleep_q, nsleep_d;
  state_e       state_q, state_d, next_cls;

  logic inc_p, dec_p, press_eff;
  logic step, step_dir;
  logic at_max_d, at_min_d;

  assign at_max = (target_q == D_MAX);
  assign at_min = (target_q == D_MIN);

  always_comb begin
    inc_p     = en & inc & ~dec;
    dec_p     = en & dec & ~inc;
    // Presses toward a limit already reached never reach the repeat counter.
    press_eff = (inc_p & ~at_max) | (dec_p & ~at_min);
  end

  pwm_step_repeat #(
    .HOLD_CYC (HOLD_CYC)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .press    (press_eff),
    .dir      (inc),
    .step     (step),
    .step_dir (step_dir)
  );

  always_comb begin
    target_d = target_q;
    if (step) begin
      target_d = step_dir ? W'(clamp_up(32'(target_q), STEP, DUTY_MAX))
                          : W'(clamp_dn(32'(target_q), STEP, DUTY_MIN));
    end

    cnt_d = '0;
    if (en && cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;

    duty_d = duty_q;
    if (!en || cnt_q == CNT_LAST) duty_d = target_q;

    pwm_d    = en & (cnt_q < duty_q);
    nsleep_d = en;
  end

  always_comb begin
    at_max_d = (target_d == D_MAX);
    at_min_d = (target_d == D_MIN);
    // Classification of the post-step target; MAX wins when the limits coincide.
    if (at_max_d && !dec_p)      next_cls = ST_MAX;
    else if (at_min_d && !inc_p) next_cls = ST_MIN;
    else if (inc_p)              next_cls = ST_INC;
    else if (dec_p)              next_cls = ST_DEC;
    else                         next_cls = ST_IDLE;

    state_d = next_cls;
    case (state_q)
      ST_MAX:  if (at_max_d && !dec_p) state_d = ST_MAX;
      ST_MIN:  if (at_min_d && !inc_p && !at_max_d) state_d = ST_MIN;
      default: state_d = next_cls;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      duty_q   <= D_INIT;
      target_q <= D_INIT;
      pwm_q    <= 1'b0;
      nsleep_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pwm_q    <= pwm_d;
      nsleep_q <= nsleep_d;
      state_q  <= state_d;
    end
  end

  assign pwm_out = pwm_q;
  assign nsleep  = nsleep_q;
  assign duty    = duty_q;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
module tb_pwm_motor_ctrl;
  import pwm_motor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, inc_a, dec_a, pwm_a, nsl_a, amax_a, amin_a;
  logic en_b, inc_b, dec_b, pwm_b, nsl_b, amax_b, amin_b;
  logic en_c, inc_c, dec_c, pwm_c, nsl_c, amax_c, amin_c;
  logic [10:0] duty_a, duty_b;
  logic [3:0]  duty_c;

  pwm_motor_ctrl dut_a (
    .clk(clk), .rst(rst), .en(en_a), .inc(inc_a), .dec(dec_a),
    .pwm_out(pwm_a), .nsleep(nsl_a), .duty(duty_a), .at_max(amax_a), .at_min(amin_a));

  pwm_motor_ctrl #(.DUTY_INIT(1948), .STEP(5)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .inc(inc_b), .dec(dec_b),
    .pwm_out(pwm_b), .nsleep(nsl_b), .duty(duty_b), .at_max(amax_b), .at_min(amin_b));

  localparam int PC = 10, IC = 5, MINC = 1, MAXC = 9, SC = 2, HC = 3;

  pwm_motor_ctrl #(.PERIOD(PC), .DUTY_INIT(IC), .DUTY_MIN(MINC), .DUTY_MAX(MAXC),
                   .STEP(SC), .HOLD_CYC(HC)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .inc(inc_c), .dec(dec_c),
    .pwm_out(pwm_c), .nsleep(nsl_c), .duty(duty_c), .at_max(amax_c), .at_min(amin_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut_c: plain integer arithmetic over the behavioural rules.
  int m_cnt, m_duty, m_tgt, m_streak;
  bit m_prev_eff, m_prev_dir, m_pwm, m_nsl;

  task automatic model_reset();
    m_cnt = 0; m_duty = IC; m_tgt = IC; m_streak = 0;
    m_prev_eff = 0; m_prev_dir = 0; m_pwm = 0; m_nsl = 0;
  endtask

  task automatic model_step(input bit e, input bit i, input bit d);
    bit press, eff;
    int nt;
    press = e && (i != d);
    eff   = press && !(i ? (m_tgt == MAXC) : (m_tgt == MINC));
    nt    = m_tgt;
    if (!eff) m_streak = 0;
    else if (m_prev_eff && (i != m_prev_dir)) m_streak = 0;
    else begin
      m_streak++;
      if (m_streak == HC) begin
        m_streak = 0;
        if (i) nt = (m_tgt + SC > MAXC) ? MAXC : m_tgt + SC;
        else   nt = (m_tgt - SC < MINC) ? MINC : m_tgt - SC;
      end
    end
    m_pwm = e && (m_cnt < m_duty);
    m_nsl = e;
    if (!e || m_cnt == PC - 1) m_duty = m_tgt;
    m_cnt = e ? (m_cnt + 1) % PC : 0;
    m_prev_eff = eff;
    m_prev_dir = i;
    m_tgt = nt;
  endtask

  function automatic logic [31:0] model_vec();
    return 32'((m_pwm << 7) | (m_nsl << 6) | (m_duty << 2) |
               ((m_tgt == MAXC) << 1) | (m_tgt == MINC));
  endfunction

  typedef struct {
    logic   en, inc, dec;
    int     n;
    int     tgt;
    logic   mx, mn;
    state_e st;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int seg;
    rst = 1'b1;
    {en_a, inc_a, dec_a} = '0;
    {en_b, inc_b, dec_b} = '0;
    {en_c, inc_c, dec_c} = '0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4, 5, 1'b0, 1'b0, ST_IDLE};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 3, 7, 1'b0, 1'b0, ST_INC};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3, 9, 1'b1, 1'b0, ST_MAX};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 5, 9, 1'b1, 1'b0, ST_MAX};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 3, 7, 1'b0, 1'b0, ST_DEC};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, ST_DEC};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4, 7, 1'b0, 1'b0, ST_IDLE};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 9, 1, 1'b0, 1'b1, ST_MIN};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4, 1, 1'b0, 1'b1, ST_MIN};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 5, 1, 1'b0, 1'b1, ST_MIN};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2, 1, 1'b0, 1'b1, ST_INC};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b1, ST_MIN};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3, 3, 1'b0, 1'b0, ST_INC};

    #23;
    check("a_rst_pwm",    32'(pwm_a), 32'd0);
    check("a_rst_nsleep", 32'(nsl_a), 32'd0);
    check("a_rst_duty",   32'(duty_a), 32'd1000);
    check("a_rst_state",  32'(dut_a.state_q), 32'(ST_IDLE));
    check("a_rst_limits", 32'({amax_a, amin_a}), 32'd0);
    check("b_rst_duty",   32'(duty_b), 32'd1948);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven sequences on the small configuration.
    for (int r = 0; r < 13; r++) begin
      en_c = tbl[r].en; inc_c = tbl[r].inc; dec_c = tbl[r].dec;
      for (int k = 0; k < tbl[r].n; k++) tick();
      check($sformatf("tbl%0d", r),
            32'({dut_c.target_q, dut_c.state_q, amax_c, amin_c, nsl_c}),
            32'((tbl[r].tgt << 6) | (int'(tbl[r].st) << 3) | (tbl[r].mx << 2) |
                (tbl[r].mn << 1) | tbl[r].en));
    end
    {en_c, inc_c, dec_c} = '0;

    // Default duty: 1000 high cycles per 2000.
    en_a = 1'b1;
    hi = 0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      hi += int'(pwm_a);
      if (k == 1)    check("a_nsleep_lat", 32'(nsl_a), 32'd1);
      if (k == 1000) check("a_last_high",  32'(pwm_a), 32'd1);
      if (k == 1001) check("a_first_low",  32'(pwm_a), 32'd0);
    end
    check("a_high_count", 32'(hi), 32'd1000);
    check("a_cnt_wrap", 32'(dut_a.cnt_q), 32'd0);

    // Hold inc 250 cycles: steps on press cycles 100 and 200 only.
    inc_a = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (k == 99)  check("a_pre_step",  32'(dut_a.target_q), 32'd1000);
      if (k == 100) check("a_step1",     32'(dut_a.target_q), 32'd1001);
      if (k == 200) check("a_step2",     32'(dut_a.target_q), 32'd1002);
    end
    inc_a = 1'b0;
    check("a_duty_shadow", 32'(duty_a), 32'd1000);
    for (int k = 0; k < 1749; k++) tick();
    check("a_duty_before_wrap", 32'(duty_a), 32'd1000);
    tick();
    check("a_duty_at_wrap", 32'(duty_a), 32'd1002);
    hi = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      hi += int'(pwm_a);
    end
    check("a_high_count_1002", 32'(hi), 32'd1002);
    check("a_no_third_step", 32'(dut_a.target_q), 32'd1002);

    // Both buttons: no press.
    inc_a = 1'b1; dec_a = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    check("a_both_target", 32'(dut_a.target_q), 32'd1002);
    check("a_both_state",  32'(dut_a.state_q), 32'(ST_IDLE));

    // Direction toggling every 60 cycles never completes a hold.
    for (int k = 0; k < 360; k++) begin
      inc_a = ((k / 60) % 2) == 0;
      dec_a = ~inc_a;
      tick();
    end
    check("a_toggle_target", 32'(dut_a.target_q), 32'd1002);

    // Disable mid-period while inc is held.
    inc_a = 1'b1; dec_a = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    en_a = 1'b0;
    tick();
    check("a_dis_outputs", 32'({pwm_a, nsl_a}), 32'd0);
    check("a_dis_cnt",     32'(dut_a.cnt_q), 32'd0);
    for (int k = 0; k < 150; k++) tick();
    check("a_dis_target",  32'(dut_a.target_q), 32'd1002);
    en_a = 1'b1; inc_a = 1'b0;
    tick();
    check("a_reen_outputs", 32'({pwm_a, nsl_a}), 32'd3);
    check("a_reen_cnt",     32'(dut_a.cnt_q), 32'd1);
    check("a_reen_duty",    32'(duty_a), 32'd1002);

    // Asynchronous reset during the high phase.
    for (int k = 0; k < 10; k++) tick();
    check("a_pre_rst_high", 32'(pwm_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("a_async_pwm",   32'(pwm_a), 32'd0);
    check("a_async_duty",  32'(duty_a), 32'd1000);
    check("a_async_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    hi = 0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      hi += int'(pwm_a);
      if (k == 1) check("a_post_rst_nsleep", 32'(nsl_a), 32'd1);
    end
    check("a_post_rst_count", 32'(hi), 32'd1000);
    en_a = 1'b0;

    // Clamp at DUTY_MAX with STEP=5 from 1948.
    check("b_init_target", 32'(dut_b.target_q), 32'd1948);
    en_b = 1'b1; inc_b = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 99) check("b_pre_clamp", 32'(dut_b.target_q), 32'd1948);
    end
    check("b_clamp_target", 32'(dut_b.target_q), 32'd1950);
    check("b_clamp_flags",  32'({amax_b, amin_b}), 32'd2);
    check("b_clamp_state",  32'(dut_b.state_q), 32'(ST_MAX));
    for (int k = 0; k < 200; k++) tick();
    check("b_hold_target",  32'(dut_b.target_q), 32'd1950);
    check("b_hold_state",   32'(dut_b.state_q), 32'(ST_MAX));
    inc_b = 1'b0; dec_b = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 1)  check("b_dec_state", 32'(dut_b.state_q), 32'(ST_DEC));
      if (k == 99) check("b_dec_pre",   32'(dut_b.target_q), 32'd1950);
    end
    check("b_dec_target", 32'(dut_b.target_q), 32'd1945);
    check("b_dec_flags",  32'({amax_b, amin_b}), 32'd0);
    {en_b, inc_b, dec_b} = '0;

    // Randomised run against the reference model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("c_rst", 32'({pwm_c, nsl_c, duty_c, amax_c, amin_c}), model_vec());
    @(negedge clk);
    rst = 1'b0;
    seg = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (seg == 0) begin
        seg   = int'($urandom_range(1, 8));
        en_c  = ($urandom % 10) != 0;
        inc_c = $urandom % 2;
        dec_c = $urandom % 2;
      end
      seg--;
      tick();
      model_step(en_c, inc_c, dec_c);
      check("c_rand", 32'({pwm_c, nsl_c, duty_c, amax_c, amin_c}), model_vec());
      if (cyc == 2000) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("c_rand_rst", 32'({pwm_c, nsl_c, duty_c, amax_c, amin_c}), model_vec());
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
